// File: rtl/dac_frame_builder_pkg.sv
// ============================================================================
// Module  : dac_pkg
// Brief   : Shared constants, state encoding and frame helpers for the DAC
//           frame builder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

    localparam logic [3:0]  DAC_CMD_WR_UPD = 4'b0011;
    localparam logic [31:0] DAC_INIT_FRAME = 32'h090C0000;

    localparam int c_frame_cmd_lsb  = 24;
    localparam int c_frame_ch_lsb   = 20;
    localparam int c_frame_code_lsb = 4;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SEND = 2'd2
    } dac_state_t;

    function automatic logic [31:0] dac_frame(input logic [3:0] ch, input logic [15:0] code);
        logic [31:0] f;
        f = '0;
        f[c_frame_cmd_lsb +: 4]   = DAC_CMD_WR_UPD;
        f[c_frame_ch_lsb +: 4]    = ch;
        f[c_frame_code_lsb +: 16] = code;
        return f;
    endfunction

    // Move cur toward tgt by at most step, never overshooting.
    function automatic logic [15:0] dac_ramp_code(input logic [15:0] cur,
                                                  input logic [15:0] tgt,
                                                  input logic [15:0] step);
        logic [15:0] d;
        if (tgt >= cur) begin
            d = tgt - cur;
            return cur + ((d < step) ? d : step);
        end else begin
            d = cur - tgt;
            return cur - ((d < step) ? d : step);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_frame_builder_rr_pick.sv
// ============================================================================
// Module  : dac_rr_pick
// Brief   : Combinational round-robin picker; searches from last_sent+1 and
//           wraps to channel 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dac_rr_pick #(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] dirty,
    input  logic [3:0]        last_sent,
    output logic [3:0]        sel,
    output logic              any
);

    always_comb begin
        sel = last_sent;
        any = |dirty;
        // Walk offsets from farthest to nearest so the closest dirty channel wins.
        for (int i = NUM_CH; i >= 1; i--) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if ((j == ((int'(last_sent) + i) % NUM_CH)) && dirty[j]) begin
                    sel = 4'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dac_frame_builder.sv
// ============================================================================
// Module  : dac_frame_builder
// Brief   : Per-channel DAC code register file that emits the reference-setup
//           frame after reset, then one write-and-update frame per changed
//           channel. Optional code ramping is compiled in with DAC_RAMP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dac_frame_builder
    import dac_pkg::*;
#(
    parameter int          NUM_CH     = 8,
    parameter logic [15:0] RESET_CODE = 16'h699A,
    parameter logic [15:0] RAMP_STEP  = 16'h0040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_we,
    input  logic [3:0]  host_addr,
    input  logic [15:0] host_data,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        busy,
    output logic        done
);

    dac_state_t        r_state, w_state_next;
    logic [15:0]       r_target [NUM_CH];
    logic [NUM_CH-1:0] r_dirty;
    logic [3:0]        r_sel, w_sel_next;
    logic              r_rewritten;
    logic [31:0]       r_frame_data, w_frame_data_next;
    logic              r_frame_valid, w_frame_valid_next;
    logic              r_done, w_done_next;

    logic [3:0]        w_pick_sel;
    logic              w_pick_any;
    logic [15:0]       w_pick_target, w_pick_code;
    logic              w_others_clean, w_sent_matches;
    logic              w_we_ok, w_accept, w_hit_sel, w_clear;

    assign w_we_ok   = host_we && ({1'b0, host_addr} < 5'(NUM_CH));
    assign w_accept  = r_frame_valid && frame_ready;
    assign w_hit_sel = w_we_ok && (host_addr == r_sel);

    dac_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .dirty     (r_dirty),
        .last_sent (r_sel),
        .sel       (w_pick_sel),
        .any       (w_pick_any)
    );

`ifdef DAC_RAMP_EN
    logic [15:0] r_current [NUM_CH];
    logic [15:0] w_pick_current, w_sel_target;

    always_comb begin
        w_pick_current = '0;
        w_sel_target   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (4'(i) == w_pick_sel) w_pick_current = r_current[i];
            if (4'(i) == r_sel)      w_sel_target   = r_target[i];
        end
    end

    assign w_pick_code    = dac_ramp_code(w_pick_current, w_pick_target, RAMP_STEP);
    assign w_sent_matches = (r_frame_data[c_frame_code_lsb +: 16] == w_sel_target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_current[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((r_state == SEND) && w_accept && (r_sel == 4'(i)))
                    r_current[i] <= r_frame_data[c_frame_code_lsb +: 16];
            end
        end
    end
`else
    logic w_unused_ramp;
    assign w_unused_ramp  = ^RAMP_STEP;
    assign w_pick_code    = w_pick_target;
    assign w_sent_matches = 1'b1;
`endif

    always_comb begin
        w_pick_target  = '0;
        w_others_clean = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (4'(i) == w_pick_sel) w_pick_target = r_target[i];
            if ((4'(i) != r_sel) && r_dirty[i]) w_others_clean = 1'b0;
        end
    end

    // A write that lands after the frame was latched must survive the accept.
    assign w_clear = (r_state == SEND) && w_accept && !r_rewritten && !w_hit_sel && w_sent_matches;

    always_comb begin
        w_state_next       = r_state;
        w_frame_valid_next = r_frame_valid;
        w_frame_data_next  = r_frame_data;
        w_sel_next         = r_sel;
        w_done_next        = 1'b0;
        case (r_state)
            INIT: begin
                w_frame_valid_next = 1'b1;
                if (w_accept) begin
                    w_frame_valid_next = 1'b0;
                    w_state_next       = IDLE;
                end
            end
            IDLE: begin
                if (w_pick_any) begin
                    w_frame_data_next  = dac_frame(w_pick_sel, w_pick_code);
                    w_frame_valid_next = 1'b1;
                    w_sel_next         = w_pick_sel;
                    w_state_next       = SEND;
                end
            end
            SEND: begin
                if (w_accept) begin
                    w_frame_valid_next = 1'b0;
                    w_state_next       = IDLE;
                    w_done_next        = w_clear && w_others_clean && !w_we_ok;
                end
            end
            default: w_state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= INIT;
            r_frame_valid <= 1'b0;
            r_frame_data  <= DAC_INIT_FRAME;
            r_sel         <= 4'(NUM_CH - 1);
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_frame_valid <= w_frame_valid_next;
            r_frame_data  <= w_frame_data_next;
            r_sel         <= w_sel_next;
            r_done        <= w_done_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_target[i] <= RESET_CODE;
            r_dirty     <= '1;
            r_rewritten <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_we_ok && (host_addr == 4'(i))) begin
                    r_target[i] <= host_data;
                    r_dirty[i]  <= 1'b1;
                end else if (w_clear && (r_sel == 4'(i))) begin
                    r_dirty[i]  <= 1'b0;
                end
            end
            case (r_state)
                IDLE:    r_rewritten <= w_we_ok && (host_addr == w_pick_sel);
                SEND:    r_rewritten <= r_rewritten || w_hit_sel;
                default: r_rewritten <= 1'b0;
            endcase
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign done        = r_done;
    assign busy        = (r_state != IDLE) || (|r_dirty);

endmodule

`default_nettype wire

// File: doc/dac_frame_builder.md
# dac_frame_builder

Upstream feeder for the 32-bit DAC serial loader. It holds the host-written 16-bit code for each DAC channel and tracks which channels have changed since they were last sent. It emits the one-time reference-setup frame after reset, then one write-and-update frame per changed channel to the downstream serializer over a valid/ready handshake. It replaces hard-wired per-channel patterns with a run-time register file driven by the GUI command path.

## Interface
Parameters:
- NUM_CH, 8, number of DAC channels (1..16)
- RESET_CODE, 16'h699A, code loaded into every channel at reset
- RAMP_STEP, 16'h0040, maximum code change per frame (used only with ramp feature)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- host_we  in  1  write strobe, one write per cycle
- host_addr  in  4  channel index; writes with host_addr >= NUM_CH ignored
- host_data  in  16  new target code
- frame_data  out  32  frame to serializer, MSB first; reset 32'h090C0000
- frame_valid  out  1  frame_data valid; reset 0
- frame_ready  in  1  serializer accepts frame when valid && ready
- busy  out  1  high while any frame pending or in flight; reset 1
- done  out  1  one-cycle pulse when the last dirty channel's frame is accepted; reset 0

## Operation
- Per-channel state: target[ch] (16b), dirty[ch]. With the ramp feature compiled in, each channel also has current[ch].
- Reset values: target = RESET_CODE, dirty = all ones, current = 0.
- Frame format: {8'b0000_0011, ch[3:0], code[15:0], 4'b0000}.
  - Command nibble is 4'b0011 (write-and-update).
- FSM states:
  - INIT: after reset release, present frame 32'h090C0000 with valid high. On accept, go to IDLE.
  - IDLE: if dirty != 0, the picker selects a channel, the frame is registered, and the FSM goes to SEND. Otherwise stay.
  - SEND: hold frame_data and frame_valid stable until accepted. On accept, clear dirty[sel] (subject to the rules below) and return to IDLE.
- Channel selection is round-robin. The search starts at last_sent+1 and wraps at NUM_CH-1 to 0. After reset, last_sent = NUM_CH-1, so the first pick is channel 0.
- Host write:
  - Sets target[addr] and dirty[addr] at the same clock edge.
  - A write on the same cycle as acceptance of that channel's frame leaves dirty set. The write wins.
  - A write to the channel currently in SEND does not alter the held frame_data.
- done pulses in the cycle after an accept that leaves dirty == 0 with no write in the same cycle.
- busy = (state != IDLE) || (dirty != 0).
- Reset mid-frame: frame_valid drops immediately. The serializer must abort its transfer on reset. All channels become dirty again and INIT is reissued.

## Timing
- First frame_valid: first rising edge after reset deasserts.
- From IDLE, a write captured at edge k gives frame_valid high after edge k+1.
- Accept at edge k gives the next frame_valid after edge k+1 at the earliest: one idle cycle between frames.
- frame_ready is ignored while frame_valid is low.
- Throughput is bounded by the serializer, which takes ~34 clk_en ticks per frame.

## Configuration
- DAC_RAMP_EN defined:
  - Code sent = current ± min(RAMP_STEP, |target − current|), unsigned 16-bit compare with no wrap.
  - On accept, current := code sent. dirty is cleared only if code sent == target.
  - Round-robin interleaves ramping channels.
- DAC_RAMP_EN undefined: code sent = target. There are no current registers, and dirty always clears on accept unless rewritten in the same cycle.

## Structure
- Package dac_pkg contains:
  - DAC_CMD_WR_UPD = 4'b0011
  - DAC_INIT_FRAME = 32'h090C0000
  - frame field position constants
  - state enum {INIT, IDLE, SEND}
- Sub-module dac_rr_pick: combinational round-robin picker. Inputs are dirty[NUM_CH-1:0] and last_sent; outputs are sel and any.

## Test plan
- Reset release, ready held high → INIT frame 32'h090C0000, then 8 frames for ch0..7 with code 16'h699A (frame ch3 = 32'h0336_99A0), then one done pulse, busy = 0.
- Idle, write ch5 = 16'hBEEF, ready high → single frame 32'h035B_EEF0 valid two edges after the write edge.
- Hold ready low for 10 cycles during SEND while writing the same channel → frame_data unchanged; after accept, the same channel is resent with the new code.
- Write ch2 in the same cycle its frame is accepted → dirty stays set, ch2 resent, done only after the second accept.
- DAC_RAMP_EN, current 0, target ch0 = 16'h0100, RAMP_STEP 16'h0040 → codes 0040, 0080, 00C0, 0100, then dirty clears. Then target 16'h00F0 → one frame with code 00F0.
- Assert reset mid-SEND → frame_valid 0 immediately; after release, the INIT frame and all 8 channels are resent.
